// File: rtl/usr_pkg.sv
// Shared types for the command-driven serial shifter:
// command mode codes and FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    LOAD = 3'b011,
    ROR  = 3'b100,
    ROL  = 3'b101,
    ASR  = 3'b110,
    CLR  = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input mode_e m);
    return m inside {SHR, SHL, ROR, ROL, ASR};
  endfunction

endpackage

// File: rtl/usr_step.sv
// One-position shift/rotate of a register value.
// Non-shift modes pass the value through unchanged.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_e            mode,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (mode)
      SHR: nxt = {ser_in_msb, cur[WIDTH-1:1]};
      SHL: nxt = {cur[WIDTH-2:0], ser_in_lsb};
      ROR: nxt = {cur[0], cur[WIDTH-1:1]};
      ROL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ASR: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/usr_serial_shifter.sv
// Command-driven universal shift register: one command per
// handshake, multi-position shifts run one bit per clock.
module usr_serial_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] dout,
  output logic             ser_out_lsb,
  output logic             ser_out_msb,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] ONE = AMT_W'(1);

  state_e           state, state_n;
  mode_e            mode_q, mode_n;
  mode_e            cmd_m, step_mode;
  logic [AMT_W-1:0] remaining, rem_n;
  logic [WIDTH-1:0] dout_n, stepped;
  logic             done_n, accept;

  assign cmd_m       = mode_e'(cmd_mode);
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state == SHIFT);
  assign accept      = cmd_valid && cmd_ready;
  assign ser_out_lsb = dout[0];
  assign ser_out_msb = dout[WIDTH-1];

  // The first step lands on the acceptance edge,
  // so the step unit sees the incoming mode in IDLE.
  assign step_mode = (state == SHIFT) ? mode_q : cmd_m;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .cur        (dout),
    .mode       (step_mode),
    .ser_in_msb (ser_in_msb),
    .ser_in_lsb (ser_in_lsb),
    .nxt        (stepped)
  );

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    rem_n   = remaining;
    dout_n  = dout;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            cmd_m == LOAD: begin
              dout_n = cmd_data;
              done_n = 1'b1;
            end
            cmd_m == CLR: begin
              dout_n = '0;
              done_n = 1'b1;
            end
            is_shift(cmd_m) && (cmd_amt != '0): begin
              dout_n = stepped;
              rem_n  = cmd_amt - ONE;
              mode_n = cmd_m;
              if (cmd_amt == ONE) done_n  = 1'b1;
              else                state_n = SHIFT;
            end
            default: done_n = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        dout_n = stepped;
        rem_n  = remaining - ONE;
        if (remaining == ONE) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= HOLD;
      remaining <= '0;
      dout      <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      remaining <= rem_n;
      dout      <= dout_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_usr_serial_shifter.sv
// Scoreboard bench: commands push the expected final value,
// a monitor pops and compares on every done pulse.
module tb_usr_serial_shifter;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_amt;
  logic [7:0] cmd_data;
  logic       ser_in_msb;
  logic       ser_in_lsb;
  logic [7:0] dout;
  logic       ser_out_lsb;
  logic       ser_out_msb;
  logic       busy;
  logic       done;

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] trace[$];
  int nb, nr, nd;

  always #5 clk = ~clk;

  usr_serial_shifter #(.WIDTH(8), .AMT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_amt     (cmd_amt),
    .cmd_data    (cmd_data),
    .ser_in_msb  (ser_in_msb),
    .ser_in_lsb  (ser_in_lsb),
    .dout        (dout),
    .ser_out_lsb (ser_out_lsb),
    .ser_out_msb (ser_out_msb),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("done_dout", 32'(dout), 32'(e));
        chk("ser_out_lsb", 32'(ser_out_lsb), 32'(e[0]));
        chk("ser_out_msb", 32'(ser_out_msb), 32'(e[7]));
      end
    end
  end

  task automatic issue(input mode_e m, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] e);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (n >= 64) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = 3'(m);
    cmd_amt   = a;
    cmd_data  = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic observe(input int cycles, output int b,
                         output int r, output int dn);
    b = 0; r = 0; dn = 0;
    trace.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      trace.push_back(dout);
      if (busy) b++;
      if (!cmd_ready) r++;
      if (done) dn++;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_mode = 3'(LOAD);
    cmd_amt = '0; cmd_data = 8'h55;
    ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    rst = 1'b0;

    issue(LOAD, 4'd0, 8'hA5, 8'hA5);
    observe(3, nb, nr, nd);
    chk("load_trace", 32'(trace[0]), 32'hA5);
    chk("load_busy", nb, 0);
    chk("load_done", nd, 1);

    issue(ROR, 4'd3, 8'h00, 8'hB4);
    observe(5, nb, nr, nd);
    chk("ror_s1", 32'(trace[0]), 32'hD2);
    chk("ror_s2", 32'(trace[1]), 32'h69);
    chk("ror_s3", 32'(trace[2]), 32'hB4);
    chk("ror_busy", nb, 2);
    chk("ror_notready", nr, 2);
    chk("ror_done", nd, 1);

    issue(LOAD, 4'd0, 8'h90, 8'h90);
    issue(ASR, 4'd2, 8'h00, 8'hE4);
    observe(3, nb, nr, nd);
    chk("asr_s1", 32'(trace[0]), 32'hC8);
    chk("asr_s2", 32'(trace[1]), 32'hE4);

    issue(LOAD, 4'd0, 8'h0F, 8'h0F);
    ser_in_msb = 1'b1;
    issue(SHR, 4'd4, 8'h00, 8'hF0);
    observe(5, nb, nr, nd);
    chk("shr_done", nd, 1);
    ser_in_msb = 1'b0;

    issue(LOAD, 4'd0, 8'hFF, 8'hFF);
    issue(SHL, 4'd10, 8'h00, 8'h00);
    observe(12, nb, nr, nd);
    chk("shl10_busy", nb, 9);
    chk("shl10_done", nd, 1);
    chk("shl10_dout", 32'(dout), 32'h00);

    issue(SHR, 4'd0, 8'h00, 8'h00);
    observe(2, nb, nr, nd);
    chk("amt0_busy", nb, 0);
    chk("amt0_done", nd, 1);

    issue(LOAD, 4'd0, 8'h3C, 8'h3C);
    issue(ROR, 4'd8, 8'h00, 8'h3C);
    observe(10, nb, nr, nd);
    chk("ror8_done", nd, 1);

    issue(CLR, 4'd0, 8'h00, 8'h00);
    observe(2, nb, nr, nd);
    chk("clr_dout", 32'(trace[0]), 32'h00);

    issue(LOAD, 4'd0, 8'h81, 8'h81);
    issue(ROL, 4'd8, 8'h00, 8'h00);
    void'(exp_q.pop_back());
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = 3'(LOAD);
    cmd_amt   = '0;
    cmd_data  = 8'h77;
    chk("busy_notready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("rol_s2", 32'(dout), 32'h06);
    @(negedge clk);
    chk("rol_s3", 32'(dout), 32'h0C);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dout", 32'(dout), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    exp_q.push_back(8'h77);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    observe(3, nb, nr, nd);
    chk("post_rst_load", nd, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
